// File: rtl/hier_node_pkg.sv
// Shared types for the hierarchical node sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hier_node_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEQ_START = 3'd1,
        ST_SEQ_WAIT  = 3'd2,
        ST_PAR_WAIT  = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Run mode encoding as seen on mode_i
    localparam logic MODE_SEQ = 1'b0;
    localparam logic MODE_PAR = 1'b1;

endpackage

// File: rtl/hier_tmo_cnt.sv
// Per-wait timeout counter: counts enabled cycles, flags the last allowed one.
// Latency: expire is combinational from the count; clear/increment take effect next cycle.
// Backpressure: none; saturates at all-ones instead of wrapping.
// Ports: clk/rst, clr (synchronous clear, wins over en), en (count this cycle),
//        limit (0 = never expire), expire (this enabled cycle is wait number 'limit').
module hier_tmo_cnt
    import hier_node_pkg::*;
#(
    parameter int TMO_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [TMO_W-1:0] limit,
    output logic             expire
);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of wait cycles already elapsed, so the current
    // wait cycle is number cnt+1; compare one bit wider so all-ones is safe.
    assign expire = (limit != '0) &&
                    (({1'b0, cnt} + (TMO_W+1)'(1)) == {1'b0, limit});

endmodule

// File: rtl/hier_node_seq.sv
// Node sequencer: starts child instances one-by-one or all at once and collects completions.
// Latency: first child start 1 cycle after accepted start_i; done_o 1 cycle after the final event.
// Backpressure: start_i ignored while busy; child waits bounded by the latched timeout.
// Ports: start_i/mode_i/tmo_i run request, child_start_o/child_done_i child handshake,
//        busy_o/done_o/err_o/done_mask_o run status, cur_idx_o child currently sequenced.
module hier_node_seq
    import hier_node_pkg::*;
#(
    parameter int NUM_CHILD = 5,
    parameter int TMO_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       mode_i,
    input  logic [TMO_W-1:0]           tmo_i,
    output logic [NUM_CHILD-1:0]       child_start_o,
    input  logic [NUM_CHILD-1:0]       child_done_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [NUM_CHILD-1:0]       done_mask_o,
    output logic [$clog2(NUM_CHILD):0] cur_idx_o
);

    localparam int IDX_W = $clog2(NUM_CHILD) + 1;

    state_t               state, state_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [TMO_W-1:0]     tmo_q, tmo_n;
    logic [NUM_CHILD-1:0] mask_n;
    logic                 err_n;
    // First PAR_WAIT cycle: the broadcast start cycle, treated like SEQ_START
    // (no done sampling, no wait counted) so one-child runs look identical in both modes.
    logic                 par_first, par_first_n;
    logic [NUM_CHILD-1:0] sel;
    logic                 cur_done, last, cnt_clr, cnt_en, expire;

    assign sel      = NUM_CHILD'(1) << idx;
    assign cur_done = |(child_done_i & sel);
    assign last     = (idx == IDX_W'(NUM_CHILD - 1));

    assign cnt_clr = ((state == ST_IDLE) && start_i) || (state == ST_SEQ_START) ||
                     ((state == ST_PAR_WAIT) && par_first);
    assign cnt_en  = (state == ST_SEQ_WAIT) || ((state == ST_PAR_WAIT) && !par_first);

    hier_tmo_cnt #(.TMO_W(TMO_W)) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .limit  (tmo_q),
        .expire (expire)
    );

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        tmo_n       = tmo_q;
        mask_n      = done_mask_o;
        err_n       = err_o;
        par_first_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    tmo_n  = tmo_i;
                    mask_n = '0;
                    err_n  = 1'b0;
                    idx_n  = '0;
                    if (mode_i == MODE_PAR) begin
                        state_n     = ST_PAR_WAIT;
                        par_first_n = 1'b1;
                    end else begin
                        state_n = ST_SEQ_START;
                    end
                end
            end
            ST_SEQ_START: state_n = ST_SEQ_WAIT;
            ST_SEQ_WAIT: begin
                // Completion beats a coincident timeout.
                if (cur_done || expire) begin
                    if (cur_done) mask_n = done_mask_o | sel;
                    else          err_n  = 1'b1;
                    if (last) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        state_n = ST_SEQ_START;
                    end
                end
            end
            ST_PAR_WAIT: begin
                if (!par_first) begin
                    mask_n = done_mask_o | child_done_i;
                    if (&mask_n) begin
                        state_n = ST_DONE;
                    end else if (expire) begin
                        err_n   = 1'b1;
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            tmo_q       <= '0;
            done_mask_o <= '0;
            err_o       <= 1'b0;
            par_first   <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            tmo_q       <= tmo_n;
            done_mask_o <= mask_n;
            err_o       <= err_n;
            par_first   <= par_first_n;
        end
    end

    always_comb begin
        child_start_o = '0;
        if (state == ST_SEQ_START)                   child_start_o = sel;
        else if ((state == ST_PAR_WAIT) && par_first) child_start_o = '1;
    end

    assign busy_o    = (state != ST_IDLE);
    assign done_o    = (state == ST_DONE);
    assign cur_idx_o = ((state == ST_SEQ_START) || (state == ST_SEQ_WAIT)) ? idx : '0;

endmodule

// File: tb/tb_hier_node_seq.sv
// Randomised and directed runs of hier_node_seq against a per-run timing model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_hier_node_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i = 1'b0;
    logic       mode_i = 1'b0;
    logic [7:0] tmo_i = 8'd0;
    logic [4:0] child_start_o;
    logic [4:0] child_done_i;
    logic       busy_o, done_o, err_o;
    logic [4:0] done_mask_o;
    logic [3:0] cur_idx_o;

    hier_node_seq #(.NUM_CHILD(5), .TMO_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .mode_i        (mode_i),
        .tmo_i         (tmo_i),
        .child_start_o (child_start_o),
        .child_done_i  (child_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .done_mask_o   (done_mask_o),
        .cur_idx_o     (cur_idx_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct { int cyc; logic [4:0] bits; int idx; } start_ev_t;
    typedef struct { int cyc; logic [4:0] mask; logic err; } done_ev_t;

    start_ev_t start_q[$];
    done_ev_t  done_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int dly[5];                       // per-child done delay after its start, 0 = never
    int due[5] = '{default: -1};
    logic [4:0] last_mask;
    logic       last_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural children: each completes with a one-cycle pulse dly[k] cycles after its start.
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (rst || done_o)         due[k] = -1;
            else if (child_start_o[k]) due[k] = (dly[k] > 0) ? cyc + dly[k] : -1;
        end
    end

    initial begin
        child_done_i = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 5; k++) child_done_i[k] = (due[k] == cyc);
        end
    end

    // Reference: a run whose start_i is sampled at the end of cycle t0.
    task automatic model(input int t0, input logic m, input int tmo, output int done_cyc);
        logic [4:0] mask = '0;
        logic       err = 1'b0;
        logic [4:0] b;
        int t, fin;
        bit all_ok;
        if (m == 1'b0) begin
            t = t0 + 1;
            for (int k = 0; k < 5; k++) begin
                b = 5'b00001 << k;
                start_q.push_back('{t, b, k});
                if (dly[k] > 0 && (tmo == 0 || dly[k] <= tmo)) begin
                    fin = t + dly[k];
                    mask[k] = 1'b1;
                end else begin
                    fin = t + tmo;
                    err = 1'b1;
                end
                t = fin + 1;
            end
            done_cyc = t;
        end else begin
            start_q.push_back('{t0 + 1, 5'b11111, 0});
            fin = t0 + 1;
            all_ok = 1'b1;
            for (int k = 0; k < 5; k++) begin
                if (dly[k] > 0 && (tmo == 0 || dly[k] <= tmo)) begin
                    mask[k] = 1'b1;
                    if (t0 + 1 + dly[k] > fin) fin = t0 + 1 + dly[k];
                end else begin
                    all_ok = 1'b0;
                end
            end
            if (!all_ok) begin
                fin = t0 + 1 + tmo;
                err = 1'b1;
            end
            done_cyc = fin + 1;
        end
        done_q.push_back('{done_cyc, mask, err});
        last_mask = mask;
        last_err  = err;
    endtask

    // Monitor: compares every start pulse and every done pulse with the scoreboard.
    always @(negedge clk) begin
        start_ev_t se;
        done_ev_t  de;
        if (!rst) begin
            if (child_start_o != '0) begin
                if (start_q.size() == 0) begin
                    chk("unexpected_start", child_start_o, 0);
                end else begin
                    se = start_q.pop_front();
                    chk("start_cycle", cyc, se.cyc);
                    chk("start_bits", child_start_o, se.bits);
                    chk("cur_idx", cur_idx_o, se.idx);
                end
            end
            if (done_o) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    de = done_q.pop_front();
                    chk("done_cycle", cyc, de.cyc);
                    chk("done_mask", done_mask_o, de.mask);
                    chk("err", err_o, de.err);
                    chk("busy_at_done", busy_o, 1);
                end
            end
        end
    end

    task automatic run(input logic m, input int tmo, input bit hold);
        int t0, dc, dc2, fin, n0, nexp;
        @(posedge clk);
        #1;
        t0 = cyc;
        mode_i  = m;
        tmo_i   = 8'(tmo);
        start_i = 1'b1;
        n0 = done_cnt;
        model(t0, m, tmo, dc);
        if (hold) begin
            // Second run accepted in the first IDLE cycle after DONE.
            model(dc + 1, m, tmo, dc2);
            while (cyc < dc + 2) begin
                @(posedge clk);
                #1;
            end
            start_i = 1'b0;
            fin  = dc2;
            nexp = 2;
        end else begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            fin  = dc;
            nexp = 1;
        end
        while (done_cnt < n0 + nexp && cyc < fin + 20) @(negedge clk);
        chk("run_complete", done_cnt - n0, nexp);
        if (done_cnt < n0 + nexp) begin
            start_q.delete();
            done_q.delete();
        end
        @(negedge clk);
        chk("idle_busy", busy_o, 0);
        chk("idle_done", done_o, 0);
        chk("hold_mask", done_mask_o, last_mask);
        chk("hold_err", err_o, last_err);
    endtask

    initial begin
        int n, n0, t0, dc, tmo;
        logic m;
        #1 rst = 1'b1;
        #2;
        chk("rst_child_start", child_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_mask", done_mask_o, 0);
        chk("rst_cur_idx", cur_idx_o, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy_o, 0);

        // Sequential, no timeout, every child takes 3 cycles.
        dly = '{3, 3, 3, 3, 3};
        run(1'b0, 0, 1'b0);
        // Parallel, staggered completions within the timeout.
        dly = '{2, 4, 6, 8, 3};
        run(1'b1, 10, 1'b0);
        // Sequential, child 2 never completes.
        dly = '{2, 1, 0, 3, 2};
        run(1'b0, 4, 1'b0);
        // Parallel, last child completes on the expiry cycle.
        dly = '{1, 2, 3, 4, 6};
        run(1'b1, 6, 1'b0);
        // Parallel timeout with children missing.
        dly = '{1, 0, 3, 9, 2};
        run(1'b1, 5, 1'b0);
        // start_i held high across a whole run.
        dly = '{1, 2, 1, 2, 1};
        run(1'b0, 0, 1'b1);
        run(1'b1, 3, 1'b1);

        // Reset while waiting on child 3.
        dly = '{3, 3, 3, 3, 3};
        @(posedge clk);
        #1;
        t0 = cyc;
        mode_i = 1'b0; tmo_i = 8'd0; start_i = 1'b1;
        model(t0, 1'b0, 0, dc);
        @(posedge clk);
        #1 start_i = 1'b0;
        n = 0;
        while (!(cur_idx_o == 4'd3 && child_start_o == '0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("reach_child3", (n < 60), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_child_start", child_start_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_err", err_o, 0);
        chk("midrst_mask", done_mask_o, 0);
        chk("midrst_cur_idx", cur_idx_o, 0);
        start_q.delete();
        done_q.delete();
        n0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_done_after_rst", done_cnt - n0, 0);
        dly = '{2, 2, 1, 3, 1};
        run(1'b0, 0, 1'b0);

        // Randomised runs.
        for (int r = 0; r < 25; r++) begin
            m   = 1'($urandom_range(0, 1));
            tmo = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            for (int k = 0; k < 5; k++)
                dly[k] = (tmo != 0 && $urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 10));
            run(m, tmo, 1'b0);
        end

        chk("start_q_empty", start_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
